// File: rtl/mem_wb_result_pipe_pkg.sv
// Shared types and constants for the EX/MEM -> MEM/WB result pipeline.
// Holds the pipeline control struct and the load-handshake state encoding.
package rv_pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [4:0]  REG_ZERO     = 5'd0;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT
  } mem_state_t;

  // Control fields of a pipeline register; the XLEN-wide result sits beside it
  // so the struct stays independent of the datapath width.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
  } pipe_ctrl_t;

  function automatic logic wb_enable(input pipe_ctrl_t c);
    return c.valid & c.reg_write & (c.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/mem_wb_result_pipe_if.sv
// Data-memory load handshake between the MEM stage and data memory.
interface mem_wb_result_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/mem_wb_result_pipe_load_ctrl.sv
// MEM-stage load controller: wait-state FSM, wait counter, stall and timeout.
module mem_load_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic rvalid,
  output logic stall,
  output logic mem_timeout
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  mem_state_t state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // The timeout cycle retires the load, so it must not also stall the pipe.
  always_comb begin
    mem_timeout = (state_q == MEM_WAIT) & req & ~rvalid & (wait_cnt_q == MAX_W);
    stall       = req & ~rvalid & ~mem_timeout;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      MEM_IDLE: begin
        if (req && !rvalid) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!req || rvalid || mem_timeout) begin
          state_d    = MEM_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = MEM_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/mem_wb_result_pipe.sv
// EX/MEM and MEM/WB result registers feeding the forwarding unit, with the
// MEM-stage load handshake and load-use hazard detection.
module mem_wb_result_pipe
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEFAULT,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic [4:0]           ex_rd,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 flush,
  mem_wb_result_pipe_if.master dmem,
  output logic                 ex_mem_reg_write,
  output logic [4:0]           ex_mem_rd,
  output logic [XLEN-1:0]      ex_mem_result,
  output logic                 mem_wb_reg_write,
  output logic [4:0]           mem_wb_rd,
  output logic [XLEN-1:0]      mem_wb_result,
  output logic                 stall,
  output logic                 load_use_hazard,
  output logic                 mem_timeout
);

  pipe_ctrl_t      exm_ctrl_q, exm_ctrl_d;
  logic [XLEN-1:0] exm_result_q, exm_result_d;
  logic            kill_pending_q, kill_pending_d;

  logic            mwb_reg_write_q, mwb_reg_write_d;
  logic [4:0]      mwb_rd_q, mwb_rd_d;
  logic [XLEN-1:0] mwb_result_q, mwb_result_d;

  logic            load_req;

  assign load_req      = exm_ctrl_q.valid & exm_ctrl_q.mem_read;
  assign dmem.mem_req  = load_req;
  assign dmem.mem_addr = exm_result_q;

  mem_load_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) u_load_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (load_req),
    .rvalid      (dmem.mem_rvalid),
    .stall       (stall),
    .mem_timeout (mem_timeout)
  );

  // A flush seen while stalled is remembered so the instruction still sitting
  // in EX is invalidated when the pipe finally advances.
  always_comb begin
    exm_ctrl_d     = exm_ctrl_q;
    exm_result_d   = exm_result_q;
    kill_pending_d = kill_pending_q;
    if (stall) begin
      if (flush) begin
        kill_pending_d = 1'b1;
      end
    end else begin
      exm_ctrl_d.valid     = ex_valid & ~flush & ~kill_pending_q;
      exm_ctrl_d.reg_write = ex_reg_write;
      exm_ctrl_d.mem_read  = ex_mem_read;
      exm_ctrl_d.rd        = ex_rd;
      exm_result_d         = ex_result;
      kill_pending_d       = 1'b0;
    end
  end

  always_comb begin
    mwb_reg_write_d = 1'b0;
    mwb_rd_d        = mwb_rd_q;
    mwb_result_d    = mwb_result_q;
    if (!stall) begin
      mwb_reg_write_d = wb_enable(exm_ctrl_q) & ~mem_timeout;
      mwb_rd_d        = exm_ctrl_q.rd;
      mwb_result_d    = load_req ? dmem.mem_rdata : exm_result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm_ctrl_q      <= '0;
      exm_result_q    <= '0;
      kill_pending_q  <= 1'b0;
      mwb_reg_write_q <= 1'b0;
      mwb_rd_q        <= '0;
      mwb_result_q    <= '0;
    end else begin
      exm_ctrl_q      <= exm_ctrl_d;
      exm_result_q    <= exm_result_d;
      kill_pending_q  <= kill_pending_d;
      mwb_reg_write_q <= mwb_reg_write_d;
      mwb_rd_q        <= mwb_rd_d;
      mwb_result_q    <= mwb_result_d;
    end
  end

  // A load in EX/MEM has no data yet, so it is never offered for forwarding.
  always_comb begin
    ex_mem_reg_write = wb_enable(exm_ctrl_q) & ~exm_ctrl_q.mem_read;
    ex_mem_rd        = exm_ctrl_q.rd;
    ex_mem_result    = exm_result_q;
    mem_wb_reg_write = mwb_reg_write_q;
    mem_wb_rd        = mwb_rd_q;
    mem_wb_result    = mwb_result_q;
    load_use_hazard  = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != REG_ZERO) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  end

endmodule

// File: tb/tb_mem_wb_result_pipe.sv
// Directed bench for mem_wb_result_pipe with a writeback scoreboard.
module tb_mem_wb_result_pipe;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        flush;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic [31:0] ex_mem_result;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_result;
  logic        stall;
  logic        load_use_hazard;
  logic        mem_timeout;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb[$];

  mem_wb_result_pipe_if #(.XLEN(32)) dmem_if ();

  mem_wb_result_pipe #(
    .XLEN     (32),
    .MAX_WAIT (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .ex_result        (ex_result),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .flush            (flush),
    .dmem             (dmem_if.master),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_rd        (ex_mem_rd),
    .ex_mem_result    (ex_mem_result),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .mem_wb_result    (mem_wb_result),
    .stall            (stall),
    .load_use_hazard  (load_use_hazard),
    .mem_timeout      (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid           = 1'b0;
    ex_reg_write       = 1'b0;
    ex_mem_read        = 1'b0;
    ex_rd              = 5'd0;
    ex_result          = 32'd0;
    id_rs1             = 5'd0;
    id_rs2             = 5'd0;
    flush              = 1'b0;
    dmem_if.mem_rvalid = 1'b0;
    dmem_if.mem_rdata  = 32'd0;
  endtask

  task automatic drive(input logic ld, input logic [4:0] rd, input logic [31:0] res);
    ex_valid     = 1'b1;
    ex_reg_write = 1'b1;
    ex_mem_read  = ld;
    ex_rd        = rd;
    ex_result    = res;
  endtask

  // Every regfile write must match the oldest expected writeback.
  always @(negedge clk) begin
    if (rst_n && mem_wb_reg_write) begin
      check("wb_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        check("wb_rd", 32'(mem_wb_rd), 32'(e[36:32]));
        check("wb_result", mem_wb_result, e[31:0]);
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ex_mem_we", 32'(ex_mem_reg_write), 32'd0);
    check("rst_mem_wb_we", 32'(mem_wb_reg_write), 32'd0);
    check("rst_mem_req", 32'(dmem_if.mem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU chain
    next(); drive(1'b0, 5'd5, 32'h1234_5678); sb.push_back({5'd5, 32'h1234_5678});
    next(); idle(); #1;
    check("alu_exm_we", 32'(ex_mem_reg_write), 32'd1);
    check("alu_exm_rd", 32'(ex_mem_rd), 32'd5);
    check("alu_exm_res", ex_mem_result, 32'h1234_5678);
    next(); #1;
    check("alu_mwb_we", 32'(mem_wb_reg_write), 32'd1);
    check("alu_mwb_rd", 32'(mem_wb_rd), 32'd5);

    // Zero-wait load
    next(); drive(1'b1, 5'd6, 32'h100); sb.push_back({5'd6, 32'hDEAD_BEEF});
    next(); idle(); dmem_if.mem_rvalid = 1'b1; dmem_if.mem_rdata = 32'hDEAD_BEEF; #1;
    check("zw_req", 32'(dmem_if.mem_req), 32'd1);
    check("zw_addr", dmem_if.mem_addr, 32'h100);
    check("zw_stall", 32'(stall), 32'd0);
    check("zw_exm_we", 32'(ex_mem_reg_write), 32'd0);
    next(); idle(); #1;
    check("zw_mwb_res", mem_wb_result, 32'hDEAD_BEEF);
    check("zw_stall2", 32'(stall), 32'd0);

    // 3-wait load, younger ALU op held in EX
    next(); drive(1'b1, 5'd8, 32'h200); sb.push_back({5'd8, 32'hCAFE_F00D});
    next(); drive(1'b0, 5'd9, 32'h99); sb.push_back({5'd9, 32'h99});
    for (int i = 0; i < 3; i++) begin
      #1;
      check("w3_stall", 32'(stall), 32'd1);
      check("w3_addr", dmem_if.mem_addr, 32'h200);
      check("w3_exm_rd", 32'(ex_mem_rd), 32'd8);
      check("w3_bubble", 32'(mem_wb_reg_write), 32'd0);
      next();
    end
    dmem_if.mem_rvalid = 1'b1; dmem_if.mem_rdata = 32'hCAFE_F00D; #1;
    check("w3_release", 32'(stall), 32'd0);
    next(); idle(); #1;
    check("w3_mwb_rd", 32'(mem_wb_rd), 32'd8);
    check("w3_exm_rd2", 32'(ex_mem_rd), 32'd9);
    check("w3_exm_we2", 32'(ex_mem_reg_write), 32'd1);
    next(); #1;
    check("w3_mwb_rd2", 32'(mem_wb_rd), 32'd9);

    // Load-use hazard
    next(); drive(1'b1, 5'd7, 32'h700); id_rs1 = 5'd3; id_rs2 = 5'd7; #1;
    check("lu_rs2", 32'(load_use_hazard), 32'd1);
    ex_rd = 5'd0; id_rs2 = 5'd0; #1;
    check("lu_x0", 32'(load_use_hazard), 32'd0);
    ex_rd = 5'd7; id_rs1 = 5'd7; #1;
    check("lu_rs1", 32'(load_use_hazard), 32'd1);
    sb.push_back({5'd7, 32'h77});
    next(); idle(); dmem_if.mem_rvalid = 1'b1; dmem_if.mem_rdata = 32'h77; #1;
    check("lu_exm_we", 32'(ex_mem_reg_write), 32'd0);
    check("lu_req", 32'(dmem_if.mem_req), 32'd1);
    check("lu_stall", 32'(stall), 32'd0);

    // Flush during stall kills the EX instruction, not the load
    next(); idle(); drive(1'b1, 5'd10, 32'h300); sb.push_back({5'd10, 32'hA5A5});
    next(); drive(1'b0, 5'd11, 32'hBB); #1;
    check("fl_stall1", 32'(stall), 32'd1);
    next(); flush = 1'b1; #1;
    check("fl_stall2", 32'(stall), 32'd1);
    next(); flush = 1'b0; dmem_if.mem_rvalid = 1'b1; dmem_if.mem_rdata = 32'hA5A5; #1;
    check("fl_release", 32'(stall), 32'd0);
    next(); idle(); #1;
    check("fl_killed", 32'(ex_mem_reg_write), 32'd0);
    check("fl_mwb_rd", 32'(mem_wb_rd), 32'd10);
    next(); #1;
    check("fl_no_wb", 32'(mem_wb_reg_write), 32'd0);

    // Timeout with MAX_WAIT=4
    next(); drive(1'b1, 5'd12, 32'h400);
    next(); idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_stall", 32'(stall), 32'd1);
      check("to_early", 32'(mem_timeout), 32'd0);
      next();
    end
    #1;
    check("to_pulse", 32'(mem_timeout), 32'd1);
    check("to_nostall", 32'(stall), 32'd0);
    next(); #1;
    check("to_pulse_end", 32'(mem_timeout), 32'd0);
    check("to_no_wb", 32'(mem_wb_reg_write), 32'd0);
    check("to_req_drop", 32'(dmem_if.mem_req), 32'd0);

    // Asynchronous reset during WAIT
    next(); drive(1'b1, 5'd13, 32'h500);
    next(); idle(); #1;
    check("rw_stall", 32'(stall), 32'd1);
    next(); #1;
    check("rw_req", 32'(dmem_if.mem_req), 32'd1);
    #1 rst_n = 1'b0; #1;
    check("rw_req0", 32'(dmem_if.mem_req), 32'd0);
    check("rw_stall0", 32'(stall), 32'd0);
    check("rw_addr0", dmem_if.mem_addr, 32'd0);
    check("rw_exm_res0", ex_mem_result, 32'd0);
    check("rw_mwb_res0", mem_wb_result, 32'd0);
    check("rw_mwb_rd0", 32'(mem_wb_rd), 32'd0);
    check("rw_to0", 32'(mem_timeout), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) next();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
